// File: rtl/gate_exh_checker.sv
// gate_exh_checker: drives every input vector of an N_IN-input gate and checks its output; define GATE_CHK_STOP_ON_FAIL_EN to end a run at the first mismatch
module gate_exh_checker #(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             gate_y,
    output logic [N_IN-1:0]  gate_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  fail_vec,
    output logic             fail_valid
);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_nx;
    logic [N_IN-1:0] vcnt;
    logic [HW-1:0] hcnt;
    logic [2:0] op_q;
    logic accept, sample, expected, mismatch, stop;

    assign gate_in = state == RUN ? vcnt : '0;
    assign busy    = state == RUN;
    assign done    = state == FINISH;

    // decode strobes, expected gate value and next state
    always_comb begin
        accept   = state == IDLE && start && op <= 3'd5;
        sample   = state == RUN && hcnt == H_LAST;
        expected = op_q == 3'd0 ? &vcnt :
                   op_q == 3'd1 ? |vcnt :
                   op_q == 3'd2 ? ~&vcnt :
                   op_q == 3'd3 ? ~|vcnt :
                   op_q == 3'd4 ? ^vcnt : ~^vcnt;
        mismatch = sample && gate_y != expected;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        stop     = &vcnt || mismatch;
`else
        stop     = &vcnt;
`endif
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (sample && stop) state_nx = FINISH;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // vector/hold counters and run results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vcnt       <= '0;
            hcnt       <= '0;
            op_q       <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (accept) begin
            vcnt       <= '0;
            hcnt       <= '0;
            op_q       <= op;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (state == RUN) begin
            hcnt <= sample ? '0 : hcnt + 1'b1;
            if (sample && !stop) vcnt <= vcnt + 1'b1;
            if (mismatch) err_count <= err_count + ERR_W'(err_count != '1);
            if (mismatch && !fail_valid) begin
                fail_vec   <= vcnt;
                fail_valid <= 1'b1;
            end
            if (sample && stop) pass <= !(fail_valid || mismatch);
        end
    end
endmodule

// File: tb/tb_gate_exh_checker.sv
// tb_gate_exh_checker: two checker instances (2-in/hold 4 and 3-in/hold 2) against a truth-table gate and a behavioural model
module tb_gate_exh_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n, start, gy, busy, done, pass, fval;
    logic [1:0][2:0] op;
    logic [1:0][7:0] gin, err, fv;
    logic [255:0] tt [2];
    int tests = 0;
    int fails = 0;
    int n_of [2] = '{2, 3};
    int h_of [2] = '{4, 2};

    bit act [2];
    int t [2];
    int len [2];
    bit [255:0] mm [2];
    int r_err [2];
    int r_fv [2];
    bit r_pass [2];
    bit r_fval [2];

    assign gin[0][7:2] = '0;
    assign gin[1][7:3] = '0;
    assign fv[0][7:2]  = '0;
    assign fv[1][7:3]  = '0;

    gate_exh_checker #(.N_IN(2), .HOLD_CYCLES(4), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .op(op[0]), .gate_y(gy[0]),
        .gate_in(gin[0][1:0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .fail_vec(fv[0][1:0]), .fail_valid(fval[0])
    );

    gate_exh_checker #(.N_IN(3), .HOLD_CYCLES(2), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .op(op[1]), .gate_y(gy[1]),
        .gate_in(gin[1][2:0]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .fail_vec(fv[1][2:0]), .fail_valid(fval[1])
    );

    // the gate under test is a truth table indexed by the driven vector
    always_comb begin
        gy[0] = tt[0][gin[0]];
        gy[1] = tt[1][gin[1]];
    end

    function automatic bit exp_bit(logic [2:0] o, int v, int n);
        int c;
        c = $countones(v & ((1 << n) - 1));
        case (o)
            3'd0:    return c == n;
            3'd1:    return c != 0;
            3'd2:    return c != n;
            3'd3:    return c == 0;
            3'd4:    return c % 2 == 1;
            default: return c % 2 == 0;
        endcase
    endfunction

    function automatic bit [255:0] ideal_tt(logic [2:0] o, int n);
        bit [255:0] r = '0;
        for (int v = 0; v < (1 << n); v++) r[v] = exp_bit(o, v, n);
        return r;
    endfunction

    function automatic bit [255:0] mis_vec(bit [255:0] tv, logic [2:0] o, int n);
        bit [255:0] r = '0;
        for (int v = 0; v < (1 << n); v++) r[v] = tv[v] != exp_bit(o, v, n);
        return r;
    endfunction

    function automatic int nmis(bit [255:0] m, int s);
        int c = 0;
        for (int k = 0; k < s; k++) c += int'(m[k]);
        return c > 255 ? 255 : c;
    endfunction

    function automatic int first_mis(bit [255:0] m, int s);
        for (int k = 0; k < s; k++) if (m[k]) return k;
        return -1;
    endfunction

    function automatic int run_len(bit [255:0] m, int n);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        int f;
        f = first_mis(m, 1 << n);
        return f < 0 ? (1 << n) : f + 1;
`else
        return (1 << n) + 0 * int'(m[0]);
`endif
    endfunction

    task automatic chk(input string nm, input int i, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, i, $time, a, e);
        end
    endtask

    // model: run position per instance, results latched when the run ends
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                act[i]    <= 1'b0;
                t[i]      <= 0;
                r_err[i]  <= 0;
                r_fv[i]   <= 0;
                r_pass[i] <= 1'b0;
                r_fval[i] <= 1'b0;
            end else if (act[i]) begin
                if (t[i] == len[i] * h_of[i]) begin
                    act[i]    <= 1'b0;
                    r_err[i]  <= nmis(mm[i], len[i]);
                    r_fv[i]   <= first_mis(mm[i], len[i]) < 0 ? 0 : first_mis(mm[i], len[i]);
                    r_fval[i] <= first_mis(mm[i], len[i]) >= 0;
                    r_pass[i] <= nmis(mm[i], len[i]) == 0;
                end else begin
                    t[i] <= t[i] + 1;
                end
            end else if (start[i] && op[i] <= 3'd5) begin
                act[i]    <= 1'b1;
                t[i]      <= 0;
                mm[i]     <= mis_vec(tt[i], op[i], n_of[i]);
                len[i]    <= run_len(mis_vec(tt[i], op[i], n_of[i]), n_of[i]);
                r_err[i]  <= 0;
                r_fv[i]   <= 0;
                r_pass[i] <= 1'b0;
                r_fval[i] <= 1'b0;
            end
        end
    end

    // compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int hh, s, f, eb, ed, eg, ee, efv, efval, ep;
            hh = h_of[i];
            if (act[i]) begin
                s     = t[i] / hh > len[i] ? len[i] : t[i] / hh;
                eb    = int'(t[i] < len[i] * hh);
                ed    = int'(t[i] == len[i] * hh);
                eg    = eb != 0 ? t[i] / hh : 0;
                ee    = nmis(mm[i], s);
                f     = first_mis(mm[i], s);
                efv   = f < 0 ? 0 : f;
                efval = int'(f >= 0);
                ep    = int'(ed != 0 && ee == 0);
            end else begin
                eb = 0; ed = 0; eg = 0;
                ee = r_err[i]; efv = r_fv[i]; efval = int'(r_fval[i]); ep = int'(r_pass[i]);
            end
            chk("busy", i, int'(busy[i]), eb);
            chk("done", i, int'(done[i]), ed);
            chk("gate_in", i, int'(gin[i]), eg);
            chk("err_count", i, int'(err[i]), ee);
            chk("fail_vec", i, int'(fv[i]), efv);
            chk("fail_valid", i, int'(fval[i]), efval);
            chk("pass", i, int'(pass[i]), ep);
        end
    end

    task automatic kick(input int i, input logic [2:0] o);
        @(negedge clk);
        start[i] = 1'b1;
        op[i]    = o;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input bit pulse, output int d);
        int c = 0;
        while (!done[i] && c < 600) begin
            @(negedge clk);
            c++;
            start[i] = pulse && (c == 5 || c == 9);
        end
        start[i] = 1'b0;
        if (!done[i]) chk("done_timeout", i, 0, 1);
        d = c;
    endtask

    task automatic reserved_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        op[i]    = 3'(6 + $urandom_range(1));
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int d, exp_d, exp_e, i, n;
        logic [2:0] o;
        bit [255:0] tv;
        rst_n = '0;
        start = '0;
        op    = '0;
        tt[0] = '0;
        tt[1] = '0;
        repeat (3) @(negedge clk);
        rst_n = '1;
        chk("reset_busy", 0, int'(busy[0]), 0);
        chk("reset_err", 0, int'(err[0]), 0);

        tt[0] = ideal_tt(3'd2, 2);
        kick(0, 3'd2);
        wait_done(0, 1'b0, d);
        chk("nand_done_at", 0, d, 16);
        chk("nand_pass", 0, int'(pass[0]), 1);
        chk("nand_err", 0, int'(err[0]), 0);
        chk("nand_fail_valid", 0, int'(fval[0]), 0);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
        exp_d = 4;
        exp_e = 1;
`else
        exp_d = 16;
        exp_e = 4;
`endif
        tt[0] = ideal_tt(3'd0, 2);
        kick(0, 3'd2);
        wait_done(0, 1'b0, d);
        chk("and_done_at", 0, d, exp_d);
        chk("and_err", 0, int'(err[0]), exp_e);
        chk("and_fail_vec", 0, int'(fv[0]), 0);
        chk("and_fail_valid", 0, int'(fval[0]), 1);
        chk("and_pass", 0, int'(pass[0]), 0);

        reserved_start(0);
        chk("op6_busy", 0, int'(busy[0]), 0);
        chk("op6_err_kept", 0, int'(err[0]), exp_e);
        chk("op6_fail_valid_kept", 0, int'(fval[0]), 1);

        tt[0] = '1;
        kick(0, 3'd2);
        wait_done(0, 1'b0, d);
        chk("stuck1_done_at", 0, d, 16);
        chk("stuck1_err", 0, int'(err[0]), 1);
        chk("stuck1_fail_vec", 0, int'(fv[0]), 3);
        chk("stuck1_pass", 0, int'(pass[0]), 0);

        tt[0] = ideal_tt(3'd2, 2);
        kick(0, 3'd2);
        repeat (5) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("rst_busy", 0, int'(busy[0]), 0);
        chk("rst_gate_in", 0, int'(gin[0]), 0);
        chk("rst_err", 0, int'(err[0]), 0);
        chk("rst_done", 0, int'(done[0]), 0);
        rst_n[0] = 1'b1;
        kick(0, 3'd2);
        wait_done(0, 1'b0, d);
        chk("after_rst_done_at", 0, d, 16);
        chk("after_rst_pass", 0, int'(pass[0]), 1);

        kick(0, 3'd2);
        wait_done(0, 1'b1, d);
        chk("pulsed_done_at", 0, d, 16);
        chk("pulsed_pass", 0, int'(pass[0]), 1);

        tt[1] = ideal_tt(3'd4, 3);
        kick(1, 3'd4);
        wait_done(1, 1'b0, d);
        chk("xor3_done_at", 1, d, 16);
        chk("xor3_pass", 1, int'(pass[1]), 1);

        for (int k = 0; k < 40; k++) begin
            i  = k % 2;
            n  = n_of[i];
            o  = 3'($urandom_range(5));
            tv = ideal_tt(o, n);
            if ($urandom_range(1) == 1)
                for (int v = 0; v < (1 << n); v++) if ($urandom_range(3) == 0) tv[v] = ~tv[v];
            tt[i] = tv;
            if ($urandom_range(3) == 0) reserved_start(i);
            kick(i, o);
            wait_done(i, 1'($urandom_range(1)), d);
            chk("rand_done_at", i, d, run_len(mis_vec(tv, o, n), n) * h_of[i]);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gate_exh_checker.md
# gate_exh_checker

- Synthesizable stimulus-and-check stage that sits directly upstream of a combinational logic gate under test.
- On `start`, drives every input combination of an N-input gate in ascending binary order and holds each for a fixed number of cycles.
- Samples the gate output at the end of each hold window and compares it against the expected function selected by `op`.
- Reports pass/fail, a saturating mismatch count and the first failing vector, so gate labs can be self-checked in simulation or on an FPGA.

## Interface
Parameters:
- `N_IN`, 2 — gate input count, legal range 1..8.
- `HOLD_CYCLES`, 4 — cycles each vector is driven, minimum 2.
- `ERR_W`, 8 — width of `err_count`.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `start`  in  1  — request a run; sampled only in IDLE.
- `op`  in  3  — expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 reserved.
- `gate_y`  in  1  — output of the gate under test.
- `gate_in`  out  N_IN  — vector driven to the gate.
- `busy`  out  1  — high while RUN is active.
- `done`  out  1  — one-cycle pulse at the end of a run.
- `pass`  out  1  — high when the last run had zero mismatches.
- `err_count`  out  ERR_W  — mismatch count; saturates at all-ones.
- `fail_vec`  out  N_IN  — first mismatching vector.
- `fail_valid`  out  1  — `fail_vec` holds a valid value.

## Operation
- **Reset values:** all outputs 0; state IDLE; vector counter and hold counter 0.
- **IDLE:**
  - `start`=1 with `op`≤5 latches `op`, clears `err_count`, `pass`, `fail_vec` and `fail_valid`, and moves to RUN.
  - `start` with `op`=6 or 7 is ignored; state and results are unchanged.
- **RUN:**
  - `gate_in` equals the vector counter; the hold counter runs 0..HOLD_CYCLES-1.
  - When the hold counter reaches HOLD_CYCLES-1, compare `gate_y` with the expected value.
  - Expected value is the reduction of `gate_in` under the latched `op`: &, |, ~&, ~|, ^, ~^.
  - On mismatch, increment `err_count` (saturating at all-ones).
  - On the first mismatch only, capture `fail_vec`=`gate_in` and set `fail_valid`=1.
  - After the compare, go to FINISH if the vector counter is at 2^N_IN-1; otherwise increment the vector counter and clear the hold counter.
- **FINISH:**
  - Assert `done` for exactly one cycle.
  - Set `pass` = (mismatch count this run == 0).
  - Drive `gate_in` to 0 and return to IDLE.
- **Result persistence:** `pass`, `err_count`, `fail_vec` and `fail_valid` hold their values until the next accepted `start` or reset.
- **Start while busy:** `start` in RUN or FINISH is ignored; there is no queuing.
- **Reset during a run:** `rst_n` low in any state returns to IDLE with reset values on the next edge; no `done` is produced.

## Timing
- `start` accepted at edge E0; `gate_in`=0 and `busy`=1 from E0 onward.
- Vector k is driven from edge E0+k·HOLD_CYCLES and sampled at edge E0+(k+1)·HOLD_CYCLES.
- `done` is high during the cycle after edge E0+2^N_IN·HOLD_CYCLES.
- `busy` falls on the same edge that raises `done`.
- `pass` and `err_count` are valid in the cycle where `done` is high.
- A new `start` can be accepted at the edge that ends the `done` cycle.
- Run length is 2^N_IN·HOLD_CYCLES+1 cycles from `start` to the end of `done`.
- Sampling at the last hold cycle gives the gate HOLD_CYCLES-1 full cycles to settle.

## Configuration
- **`GATE_CHK_STOP_ON_FAIL_EN` defined:**
  - The first mismatch ends the run: the next state after that compare is FINISH.
  - `err_count` is therefore 0 or 1.
  - `done` arrives early, at edge E0+(k+1)·HOLD_CYCLES where k is the failing vector.
- **Undefined:** every vector is always applied and all mismatches are counted.

## Test plan
- **Ideal NAND, full run:** N_IN=2, HOLD_CYCLES=4, `op`=2, `gate_y`=~&`gate_in`.
  - `gate_in` steps 00→01→10→11, 4 cycles each.
  - `done` 16 cycles after acceptance; `pass`=1, `err_count`=0, `fail_valid`=0.
- **Wrong gate (AND wired in):** `op`=2 with an AND model.
  - Without the macro: `err_count`=4, `fail_vec`=00, `fail_valid`=1, `pass`=0.
  - With `GATE_CHK_STOP_ON_FAIL_EN`: `err_count`=1, `done` at E0+4.
- **Stuck-at-1 output:** `op`=2, `gate_y` tied to 1.
  - `err_count`=1, `fail_vec`=11, `pass`=0.
- **Mid-run reset:** `rst_n` low at E0+6.
  - Next cycle: `busy`=0, `gate_in`=0, `err_count`=0, and no `done` pulse.
  - A following `start` runs normally with `pass`=1.
- **Ignored starts:**
  - `start` pulses during RUN do not restart the run; `done` stays at E0+16.
  - `start` with `op`=6 in IDLE leaves `busy`=0 and the previous results unchanged.
- **Three-input XOR:** N_IN=3, HOLD_CYCLES=2, `op`=4, ideal XOR model.
  - 8 vectors; `done` at E0+16; `pass`=1.
